// File: rtl/id_ctrl_pkg.sv
// Shared types and constants for the student-ID sequence controller.
// Imported by the interface, the scan mux and the controller top.
package id_ctrl_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SEED,
    ST_RUN,
    ST_PAUSE
  } state_e;

endpackage

// File: rtl/id_seq_ctrl_if.sv
// Button, generator and display signals of the ID sequence controller.
// master = controller side, slave = board/generator/decoder side.
interface id_seq_ctrl_if #(
  parameter int NDIG  = 4,
  parameter int CNT_W = 8
);
  import id_ctrl_pkg::*;

  logic                    start;
  logic                    stop;
  logic                    step;
  logic                    restart;
  logic [DIGIT_W-1:0]      hex_in;
  logic                    gen_en;
  logic                    gen_clr;
  logic [DIGIT_W*NDIG-1:0] window;
  logic [NDIG-1:0]         an;
  logic [DIGIT_W-1:0]      seg_hex;
  logic                    running;
  logic                    wrap;
  logic [CNT_W-1:0]        wrap_cnt;

  modport master (
    input  start, stop, step, restart, hex_in,
    output gen_en, gen_clr, window, an, seg_hex, running, wrap, wrap_cnt
  );

  modport slave (
    output start, stop, step, restart, hex_in,
    input  gen_en, gen_clr, window, an, seg_hex, running, wrap, wrap_cnt
  );

endinterface

// File: rtl/id_scan_mux.sv
// Free-running display scan: one-hot anode rotator held SCAN_DIV cycles per
// digit, and a combinational mux presenting the selected window digit.
module id_scan_mux
  import id_ctrl_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DIGIT_W*NDIG-1:0] i_window,
  output logic [NDIG-1:0]         o_an,
  output logic [DIGIT_W-1:0]      o_seg_hex
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [SCAN_W-1:0] r_cnt;
  logic [NDIG-1:0]   r_an;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_an  <= {{(NDIG-1){1'b0}}, 1'b1};
    end else if (r_cnt == SCAN_LAST) begin
      r_cnt <= '0;
      r_an  <= {r_an[NDIG-2:0], r_an[NDIG-1]};
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // NOTE: default assignment first so the mux can never infer a latch.
  always_comb begin
    o_seg_hex = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (r_an[k]) o_seg_hex = i_window[k*DIGIT_W +: DIGIT_W];
    end
  end

  assign o_an = r_an;

endmodule

// File: rtl/id_seq_ctrl.sv
// Run/pause/single-step controller for the 4-bit student-ID digit generator:
// advance enables, capture window, wrap detection and display scan.
module id_seq_ctrl
  import id_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 2,
  parameter int CNT_W    = 8
) (
  input logic           clk,
  input logic           reset,
  id_seq_ctrl_if.master bus
);

  localparam int WIN_W  = DIGIT_W * NDIG;
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  state_e             r_state;
  logic [TICK_W-1:0]  r_tick;
  logic               r_cap_pend;
  logic [DIGIT_W-1:0] r_first;
  logic [WIN_W-1:0]   r_window;
  logic [CNT_W-1:0]   r_wrap_cnt;
  logic               r_gen_en;
  logic               r_gen_clr;
  logic               r_wrap;
  logic               r_running;
  logic               w_enter_clear;

  assign w_enter_clear = (r_state == ST_IDLE) ? bus.start : bus.restart;

  // NOTE: sequential state uses non-blocking assignments only; where two
  // assignments hit the same register the later one wins, which is how the
  // clear path below overrides capture and the per-state actions.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_tick     <= '0;
      r_cap_pend <= 1'b0;
      r_first    <= '0;
      r_window   <= '0;
      r_wrap_cnt <= '0;
      r_gen_en   <= 1'b0;
      r_gen_clr  <= 1'b1;
      r_wrap     <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_gen_en   <= 1'b0;
      r_gen_clr  <= 1'b0;
      r_wrap     <= 1'b0;
      r_running  <= 1'b0;
      r_cap_pend <= r_gen_en;

      // The generator presents the new digit the cycle after gen_en.
      if (r_cap_pend) begin
        r_window <= {r_window[WIN_W-DIGIT_W-1:0], bus.hex_in};
        if (bus.hex_in == r_first) begin
          r_wrap     <= 1'b1;
          r_wrap_cnt <= r_wrap_cnt + 1'b1;
        end
      end

      unique case (r_state)
        ST_IDLE:  r_gen_clr <= 1'b1;
        ST_CLEAR: r_state   <= ST_SEED;
        ST_SEED: begin
          r_first   <= bus.hex_in;
          r_window  <= {{(WIN_W-DIGIT_W){1'b0}}, bus.hex_in};
          r_state   <= ST_RUN;
          r_running <= 1'b1;
        end
        ST_RUN: begin
          if (bus.stop) begin
            r_state <= ST_PAUSE;
          end else begin
            r_running <= 1'b1;
            if (r_tick == TICK_LAST) begin
              r_tick   <= '0;
              r_gen_en <= 1'b1;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (bus.step && !r_cap_pend) r_gen_en <= 1'b1;
          if (bus.start && !bus.stop) begin
            r_state   <= ST_RUN;
            r_tick    <= '0;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_gen_clr <= 1'b1;
        end
      endcase

      // Entering CLEAR wipes the window and drops any pending capture.
      if (w_enter_clear) begin
        r_state    <= ST_CLEAR;
        r_gen_clr  <= 1'b1;
        r_gen_en   <= 1'b0;
        r_running  <= 1'b0;
        r_wrap     <= 1'b0;
        r_cap_pend <= 1'b0;
        r_tick     <= '0;
        r_window   <= '0;
        r_wrap_cnt <= '0;
      end
    end
  end

  id_scan_mux #(
    .NDIG     (NDIG),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .i_window  (r_window),
    .o_an      (bus.an),
    .o_seg_hex (bus.seg_hex)
  );

  assign bus.gen_en   = r_gen_en;
  assign bus.gen_clr  = r_gen_clr;
  assign bus.window   = r_window;
  assign bus.running  = r_running;
  assign bus.wrap     = r_wrap;
  assign bus.wrap_cnt = r_wrap_cnt;

endmodule

// File: tb/tb_id_seq_ctrl.sv
// Bench for id_seq_ctrl: behavioural digit generator (4,1,0,7,3,2), a
// cycle-level reference of the controller's rules and directed scenarios.
module tb_id_seq_ctrl;

  localparam int TICK_DIV = 4;
  localparam int NDIG     = 4;
  localparam int SCAN_DIV = 2;
  localparam int CNT_W    = 8;
  localparam int SEQ_LEN  = 6;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  id_seq_ctrl_if #(.NDIG(NDIG), .CNT_W(CNT_W)) bus ();

  id_seq_ctrl #(
    .TICK_DIV (TICK_DIV),
    .NDIG     (NDIG),
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [3:0] seq_at(input int i);
    case (i % SEQ_LEN)
      0:       return 4'd4;
      1:       return 4'd1;
      2:       return 4'd0;
      3:       return 4'd7;
      4:       return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  // Generator: clears to the first digit, advances on gen_en.
  int gen_idx = 0;
  always @(posedge clk) begin
    if (bus.gen_clr === 1'b1)     gen_idx <= 0;
    else if (bus.gen_en === 1'b1) gen_idx <= (gen_idx + 1) % SEQ_LEN;
  end
  assign bus.hex_in = seq_at(gen_idx);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference: mode, age in RUN, list of captured digits, scan cycle count.
  localparam int M_IDLE = 0, M_CLEAR = 1, M_SEED = 2, M_RUN = 3, M_PAUSE = 4;
  int         m_mode, m_age, m_ncap, m_scan, m_wraps;
  bit         m_gen, m_cap, m_clr, m_run, m_wrap;
  bit         m_valid = 1'b0;
  logic [3:0] m_digits[$];

  always @(posedge clk) begin : model_step
    int nxt;
    bit n_gen, n_wrap, n_cap, kill;
    if (reset) begin
      m_mode = M_IDLE; m_age = 0; m_ncap = 0; m_scan = 0; m_wraps = 0;
      m_gen = 0; m_cap = 0; m_clr = 1; m_run = 0; m_wrap = 0;
      m_digits.delete();
      m_valid = 1'b1;
    end else if (m_valid) begin
      kill   = bus.restart && (m_mode != M_IDLE);
      n_gen  = 0;
      n_wrap = 0;
      n_cap  = m_gen && !kill;
      nxt    = m_mode;
      m_scan++;
      if (m_cap && !kill) begin
        m_ncap++;
        m_digits.push_back(seq_at(m_ncap));
        if (m_digits.size() > NDIG) void'(m_digits.pop_front());
        if (seq_at(m_ncap) == seq_at(0)) begin
          n_wrap  = 1;
          m_wraps = (m_wraps + 1) % (1 << CNT_W);
        end
      end
      case (m_mode)
        M_IDLE:  if (bus.start) nxt = M_CLEAR;
        M_CLEAR: nxt = M_SEED;
        M_SEED: begin
          nxt = M_RUN;
          m_digits.delete();
          m_digits.push_back(seq_at(0));
          m_ncap = 0;
          m_age  = 0;
        end
        M_RUN: begin
          if (bus.stop) nxt = M_PAUSE;
          else begin
            if (m_age % TICK_DIV == TICK_DIV - 1) n_gen = 1;
            m_age++;
          end
        end
        default: begin
          if (bus.step && !m_cap) n_gen = 1;
          if (bus.start && !bus.stop) begin
            nxt   = M_RUN;
            m_age = 0;
          end
        end
      endcase
      if (kill || (m_mode == M_IDLE && bus.start)) begin
        nxt = M_CLEAR;
        m_digits.delete();
        m_wraps = 0;
        m_age   = 0;
        n_gen   = 0;
        n_wrap  = 0;
        n_cap   = 0;
      end
      m_mode = nxt;
      m_gen  = n_gen;
      m_cap  = n_cap;
      m_wrap = n_wrap;
      m_clr  = (nxt == M_IDLE) || (nxt == M_CLEAR);
      m_run  = (nxt == M_RUN);
    end
  end

  function automatic logic [4*NDIG-1:0] exp_window();
    logic [4*NDIG-1:0] w = '0;
    for (int k = 0; k < NDIG && k < m_digits.size(); k++)
      w[4*k +: 4] = m_digits[m_digits.size() - 1 - k];
    return w;
  endfunction

  function automatic int exp_scan_idx();
    return (m_scan / SCAN_DIV) % NDIG;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      logic [NDIG-1:0]   a;
      logic [4*NDIG-1:0] w;
      a = 1;
      a = a << exp_scan_idx();
      w = exp_window();
      check("gen_en",   32'(bus.gen_en),   32'(m_gen));
      check("gen_clr",  32'(bus.gen_clr),  32'(m_clr));
      check("running",  32'(bus.running),  32'(m_run));
      check("wrap",     32'(bus.wrap),     32'(m_wrap));
      check("wrap_cnt", 32'(bus.wrap_cnt), 32'(m_wraps));
      check("window",   32'(bus.window),   32'(w));
      check("an",       32'(bus.an),       32'(a));
      check("seg_hex",  32'(bus.seg_hex),  32'(w[4*exp_scan_idx() +: 4]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    int n;
    logic [3:0] scan_an [4];
    logic [3:0] scan_hex[4];
    scan_an  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    scan_hex = '{4'h7, 4'h0, 4'h1, 4'h4};

    bus.start = 0; bus.stop = 0; bus.step = 0; bus.restart = 0;
    cyc(); cyc();
    check("rst_gen_clr",  32'(bus.gen_clr),  32'(1));
    check("rst_window",   32'(bus.window),   32'(0));
    check("rst_an",       32'(bus.an),       32'(1));
    check("rst_running",  32'(bus.running),  32'(0));
    check("rst_wrap_cnt", 32'(bus.wrap_cnt), 32'(0));

    // Scenario 1: start, seed, three advances.
    reset = 0;
    cyc();
    bus.start = 1;
    cyc();
    bus.start = 0;
    check("clear_gen_clr", 32'(bus.gen_clr), 32'(1));
    cyc();
    check("seed_gen_clr", 32'(bus.gen_clr), 32'(0));
    cyc();
    check("run_running", 32'(bus.running), 32'(1));
    check("seed_window", 32'(bus.window),  32'h0004);
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      cyc();
      pulses += int'(bus.gen_en);
    end
    check("run_3_pulses", 32'(pulses), 32'(3));
    check("win_4107",     32'(bus.window), 32'h4107);

    // Scenario 2: sixth advance recaptures the first digit.
    for (int i = 0; i < 12; i++) cyc();
    check("wrap_pulse", 32'(bus.wrap),     32'(1));
    check("wrap_cnt_1", 32'(bus.wrap_cnt), 32'(1));
    check("win_7324",   32'(bus.window),   32'h7324);
    cyc();
    check("wrap_done", 32'(bus.wrap), 32'(0));

    // Scenario 3: stop on the tick terminal, then single steps.
    bus.stop = 1;
    cyc();
    bus.stop = 0;
    check("stop_no_gen", 32'(bus.gen_en),  32'(0));
    check("pause_run",   32'(bus.running), 32'(0));
    pulses = 0;
    cyc(); pulses += int'(bus.gen_en); bus.step = 1;
    cyc(); pulses += int'(bus.gen_en); bus.step = 0;
    cyc(); pulses += int'(bus.gen_en); bus.step = 1;
    cyc(); pulses += int'(bus.gen_en); bus.step = 0;
    check("step_win_3241", 32'(bus.window), 32'h3241);
    cyc(); pulses += int'(bus.gen_en); bus.step = 1;
    cyc(); pulses += int'(bus.gen_en); bus.step = 0;
    cyc(); pulses += int'(bus.gen_en);
    cyc(); pulses += int'(bus.gen_en);
    check("step_2_pulses", 32'(pulses),     32'(2));
    check("step_win_2410", 32'(bus.window), 32'h2410);

    // Scenario 4: restart while a capture is pending.
    bus.start = 1;
    cyc();
    bus.start = 0;
    check("resume_running", 32'(bus.running), 32'(1));
    for (int i = 0; i < 4; i++) cyc();
    check("resume_gen_en", 32'(bus.gen_en), 32'(1));
    cyc();
    bus.restart = 1;
    cyc();
    bus.restart = 0;
    check("rs_gen_clr",  32'(bus.gen_clr),  32'(1));
    check("rs_window",   32'(bus.window),   32'(0));
    check("rs_wrap_cnt", 32'(bus.wrap_cnt), 32'(0));
    cyc();
    check("rs_seed_window", 32'(bus.window), 32'(0));
    cyc();
    check("rs_run_window", 32'(bus.window), 32'h0004);

    // Scenario 5: pause with 4107 held (stop lands on a pending capture), scan.
    for (int i = 0; i < 13; i++) cyc();
    bus.stop = 1;
    cyc();
    bus.stop = 0;
    check("hold_win_4107", 32'(bus.window), 32'h4107);
    n = 0;
    while (bus.an !== 4'b1000 && n < 16) begin cyc(); n++; end
    while (bus.an !== 4'b0001 && n < 32) begin cyc(); n++; end
    check("scan_sync", 32'(n < 32), 32'(1));
    for (int i = 0; i < 2 * NDIG; i++) begin
      check("scan_an",  32'(bus.an),      32'(scan_an[i/2]));
      check("scan_hex", 32'(bus.seg_hex), 32'(scan_hex[i/2]));
      cyc();
    end

    // Scenario 6: reset mid-RUN with a capture pending.
    bus.start = 1;
    cyc();
    bus.start = 0;
    for (int i = 0; i < 5; i++) cyc();
    reset = 1;
    cyc();
    check("mid_rst_gen_en",   32'(bus.gen_en),   32'(0));
    check("mid_rst_gen_clr",  32'(bus.gen_clr),  32'(1));
    check("mid_rst_window",   32'(bus.window),   32'(0));
    check("mid_rst_an",       32'(bus.an),       32'(1));
    check("mid_rst_seg_hex",  32'(bus.seg_hex),  32'(0));
    check("mid_rst_running",  32'(bus.running),  32'(0));
    check("mid_rst_wrap_cnt", 32'(bus.wrap_cnt), 32'(0));
    reset = 0;
    for (int i = 0; i < 4; i++) cyc();
    check("idle_needs_start", 32'(bus.running), 32'(0));
    check("idle_gen_clr",     32'(bus.gen_clr), 32'(1));
    bus.start = 1;
    cyc();
    bus.start = 0;
    cyc();
    cyc();
    check("restart_running", 32'(bus.running), 32'(1));
    check("restart_window",  32'(bus.window),  32'h0004);
    for (int i = 0; i < 6; i++) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
